// File: rtl/serial_adder_pkg.sv
// Shared constants for the adder family: state encoding and default widths.
package serial_adder_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_APPROX_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, time-shared across all bit positions by the sequencer.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first, with an
// optional approximate low-bit mode and valid/ready on both sides.
module serial_fa_sequencer
    import serial_adder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int IDX_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [IDX_W-1:0] bit_idx
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             approx_q, approx_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

    logic cell_a, cell_b, cell_s, cell_c;
    logic approx_bit, bit_s, bit_c;

    fa_cell u_cell (
        .a     (cell_a),
        .b     (cell_b),
        .c     (carry_q),
        .sum   (cell_s),
        .carry (cell_c)
    );

    // Low bits in approx mode bypass the cell: OR for sum, carry only out of the top approx bit.
    always_comb begin
        cell_a     = a_q[bit_idx_q];
        cell_b     = b_q[bit_idx_q];
        approx_bit = approx_q && (int'(bit_idx_q) < APPROX_BITS);
        bit_s      = cell_s;
        bit_c      = cell_c;
        if (approx_bit) begin
            bit_s = cell_a | cell_b;
            bit_c = (int'(bit_idx_q) == APPROX_BITS - 1) ? (cell_a & cell_b) : 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        approx_d  = approx_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = in_a;
                    b_d       = in_b;
                    approx_d  = in_approx;
                    carry_d   = in_approx ? 1'b0 : in_cin;
                    sum_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                carry_d = bit_c;
                if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
                    bit_idx_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            approx_q  <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            approx_q  <= approx_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign bit_idx   = bit_idx_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Directed-vector bench for serial_fa_sequencer (WIDTH=16, APPROX_BITS=4).
module tb_serial_fa_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_approx = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          busy;
    logic [3:0]    bit_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_fa_sequencer #(.WIDTH(W), .APPROX_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy), .bit_idx(bit_idx)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         approx;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int cnt;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_approx = v.approx;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble inputs after acceptance; result must not see them
        in_a = ~v.a; in_b = v.b ^ 16'h5A5A; in_cin = ~v.cin; in_approx = ~v.approx;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'd16);
        chk({tag, " sum"}, 32'(out_sum), 32'(v.sum));
        chk({tag, " cout"}, 32'(out_cout), 32'(v.cout));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle after hs"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        int cnt;
        int t_first, t_second;
        logic [W-1:0] s_first, s_second;
        logic pulsed;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0};
        vecs[4] = '{16'h0008, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};
        vecs[8] = '{16'h00F0, 16'h0010, 1'b1, 1'b1, 16'h0100, 1'b0};

        #2;
        chk("reset flags", {28'd0, out_valid, busy, in_ready, out_cout}, 32'h2);
        chk("reset sum", 32'(out_sum), 32'd0);
        chk("reset bit_idx", 32'(bit_idx), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // backpressure: DONE held 5 cycles with new operands presented
        @(negedge clk);
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'h7777; in_b = 16'h0101; in_cin = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        chk("bp latency", 32'(cnt), 32'd16);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp sum hold", 32'(out_sum), 32'h3333);
            chk("bp flags", {29'd0, out_valid, in_ready, out_cout}, 32'h4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp in_ready after hs", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp not re-accepted", 32'(busy), 32'd0);

        // reset mid-run at bit 7
        @(negedge clk);
        in_a = 16'h00FF; in_b = 16'h0F0F; in_cin = 1'b0; in_approx = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (bit_idx != 4'd7 && cnt < 40) begin @(posedge clk); #1; cnt++; end
        chk("reach bit 7", 32'(bit_idx), 32'd7);
        rst = 1'b1;
        #1;
        chk("abort flags", {29'd0, out_valid, busy, in_ready}, 32'h1);
        chk("abort bit_idx", 32'(bit_idx), 32'd0);
        @(negedge clk); rst = 1'b0;
        pulsed = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) pulsed = 1'b1;
        end
        chk("no pulse after abort", 32'(pulsed), 32'd0);
        v = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0};
        run_op(v, "post-reset");

        // back-to-back with in_valid and out_ready tied high
        @(negedge clk);
        in_a = 16'h0101; in_b = 16'h0202; in_cin = 1'b0; in_approx = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_a = 16'h1000; in_b = 16'h0FFF;
        t_first = -1; t_second = -1; s_first = '0; s_second = '0;
        for (int k = 1; k <= 60 && t_second < 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (t_first < 0) begin t_first = k; s_first = out_sum; end
                else begin t_second = k; s_second = out_sum; end
            end
        end
        in_valid = 1'b0;
        chk("b2b first latency", 32'(t_first), 32'd16);
        chk("b2b spacing", 32'(t_second - t_first), 32'd18);
        chk("b2b sum1", 32'(s_first), 32'h0303);
        chk("b2b sum2", 32'(s_second), 32'h1FFF);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("final reset busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
